// File: rtl/temporizador_ctrl.sv
// rtl/temporizador_ctrl.sv - run-control sequencer for the seconds timer
// Conditions the push-buttons, runs the IDLE/RUN/PAUSE/DONE FSM and mirrors elapsed seconds.
module temporizador_ctrl #(
    parameter int CLKS_PER_SEC = 50000000,
    parameter int TIME_LIMIT   = 60
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       btn_start_n,
    input  logic       btn_pause_n,
    input  logic       btn_clear_n,
    input  logic       game_over,
    output logic       tmr_reset,
    output logic       tmr_stop,
    output logic [1:0] state,
    output logic       timeout,
    output logic [9:0] elapsed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [26:0] PRE_MAX = 27'(CLKS_PER_SEC - 1);
    localparam logic [9:0]  LIMIT   = 10'(TIME_LIMIT);

    state_t      r_state;
    logic        r_tmr_reset;
    logic        r_timeout;
    logic [26:0] r_pre;
    logic [9:0]  r_elapsed;

    // Bit order for all button vectors: {clear, pause, start}
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_edge;

    logic [2:0] w_btn;
    logic [2:0] w_ev;
    logic       w_start_ev;
    logic       w_pause_ev;
    logic       w_clear_ev;
    logic       w_adv;
    logic       w_roll;
    logic       w_limit;

    assign w_btn      = ~{btn_clear_n, btn_pause_n, btn_start_n};
    assign w_ev       = r_sync2 & ~r_edge;
    assign w_start_ev = w_ev[0];
    assign w_pause_ev = w_ev[1];
    assign w_clear_ev = w_ev[2];

    // Same enable as the timer (not stopped, not in reset) keeps the count in lockstep
    assign w_adv   = (r_state == RUN) && !r_tmr_reset;
    assign w_roll  = w_adv && (r_pre == PRE_MAX);
    assign w_limit = w_roll && ((r_elapsed + 10'd1) == LIMIT);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_edge  <= 3'b000;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_edge  <= r_sync2;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_pre     <= 27'd0;
            r_elapsed <= 10'd0;
        end else if (r_tmr_reset) begin
            r_pre     <= 27'd0;
            r_elapsed <= 10'd0;
        end else if (w_adv) begin
            if (w_roll) begin
                r_pre     <= 27'd0;
                r_elapsed <= r_elapsed + 10'd1;
            end else begin
                r_pre <= r_pre + 27'd1;
            end
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tmr_reset <= 1'b1;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tmr_reset <= 1'b1;
                    r_timeout   <= 1'b0;
                    if (w_start_ev && !w_clear_ev) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_tmr_reset <= 1'b0;
                    if (w_clear_ev) begin
                        r_state     <= IDLE;
                        r_tmr_reset <= 1'b1;
                    end else if (game_over) begin
                        r_state <= DONE;
                    end else if (w_limit) begin
                        r_state   <= DONE;
                        r_timeout <= 1'b1;
                    end else if (w_pause_ev) begin
                        r_state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (w_clear_ev) begin
                        r_state     <= IDLE;
                        r_tmr_reset <= 1'b1;
                    end else if (w_start_ev || w_pause_ev) begin
                        r_state <= RUN;
                    end
                end
                DONE: begin
                    if (w_clear_ev) begin
                        r_state     <= IDLE;
                        r_tmr_reset <= 1'b1;
                        r_timeout   <= 1'b0;
                    end else if (w_start_ev) begin
                        r_state     <= RUN;
                        r_tmr_reset <= 1'b1;
                        r_timeout   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_tmr_reset <= 1'b1;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    assign tmr_reset = r_tmr_reset;
    assign tmr_stop  = (r_state != RUN);
    assign state     = r_state;
    assign timeout   = r_timeout;
    assign elapsed   = r_elapsed;

endmodule

// File: tb/tb_temporizador_ctrl.sv
// tb/tb_temporizador_ctrl.sv - directed bench for temporizador_ctrl
// Runs with CLKS_PER_SEC=4, TIME_LIMIT=3 against a behavioural timer model.
module tb_temporizador_ctrl;

    logic       clk_50;
    logic       reset;
    logic       btn_start_n;
    logic       btn_pause_n;
    logic       btn_clear_n;
    logic       game_over;
    logic       tmr_reset;
    logic       tmr_stop;
    logic [1:0] state;
    logic       timeout;
    logic [9:0] elapsed;

    int n_tests;
    int n_fail;

    logic [9:0] m_cnt;
    logic [2:0] m_pre;

    temporizador_ctrl #(.CLKS_PER_SEC(4), .TIME_LIMIT(3)) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .btn_start_n(btn_start_n),
        .btn_pause_n(btn_pause_n),
        .btn_clear_n(btn_clear_n),
        .game_over  (game_over),
        .tmr_reset  (tmr_reset),
        .tmr_stop   (tmr_stop),
        .state      (state),
        .timeout    (timeout),
        .elapsed    (elapsed)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Seconds timer driven by the controller outputs
    always_ff @(posedge clk_50) begin
        if (tmr_reset) begin
            m_pre <= 3'd0;
            m_cnt <= 10'd0;
        end else if (!tmr_stop) begin
            if (m_pre == 3'd3) begin
                m_pre <= 3'd0;
                m_cnt <= m_cnt + 10'd1;
            end else begin
                m_pre <= m_pre + 3'd1;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    // Pins low for one cycle; returns just after the edge where the FSM reacts
    task automatic press(input logic s, input logic p, input logic c);
        btn_start_n = ~s;
        btn_pause_n = ~p;
        btn_clear_n = ~c;
        tick(1);
        btn_start_n = 1'b1;
        btn_pause_n = 1'b1;
        btn_clear_n = 1'b1;
        tick(2);
    endtask

    task automatic do_reset;
        game_over = 1'b0;
        reset     = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        btn_start_n = 1'b1;
        btn_pause_n = 1'b1;
        btn_clear_n = 1'b1;
        game_over   = 1'b0;
        tick(3);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        n_tests++; if (tmr_reset !== 1'b1) begin n_fail++; $display("FAIL reset_tmr_reset got %b exp 1", tmr_reset); end
        n_tests++; if (tmr_stop !== 1'b1) begin n_fail++; $display("FAIL reset_tmr_stop got %b exp 1", tmr_stop); end
        n_tests++; if (elapsed !== 10'd0) begin n_fail++; $display("FAIL reset_elapsed got %0d exp 0", elapsed); end
        n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        reset = 1'b0;
        tick(1);
        press(1'b0, 1'b1, 1'b0);
        tick(2);
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_pause_ignored got %0d exp 0", state); end
    endtask

    task automatic test_start_timeout;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state got %0d exp 1", state); end
        n_tests++; if (tmr_reset !== 1'b1) begin n_fail++; $display("FAIL start_pulse_hi got %b exp 1", tmr_reset); end
        tick(1);
        n_tests++; if (tmr_reset !== 1'b0) begin n_fail++; $display("FAIL start_pulse_lo got %b exp 0", tmr_reset); end
        tick(3);
        n_tests++; if (elapsed !== 10'd0) begin n_fail++; $display("FAIL start_e0 got %0d exp 0", elapsed); end
        tick(1);
        n_tests++; if (elapsed !== 10'd1) begin n_fail++; $display("FAIL start_e1 got %0d exp 1", elapsed); end
        tick(4);
        n_tests++; if (elapsed !== 10'd2) begin n_fail++; $display("FAIL start_e2 got %0d exp 2", elapsed); end
        tick(3);
        n_tests++; if (state !== 2'd1 || elapsed !== 10'd2) begin n_fail++; $display("FAIL pre_limit got st=%0d e=%0d exp st=1 e=2", state, elapsed); end
        tick(1);
        n_tests++; if (elapsed !== 10'd3) begin n_fail++; $display("FAIL limit_elapsed got %0d exp 3", elapsed); end
        n_tests++; if (state !== 2'd3) begin n_fail++; $display("FAIL limit_state got %0d exp 3", state); end
        n_tests++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL limit_timeout got %b exp 1", timeout); end
        n_tests++; if (tmr_stop !== 1'b1) begin n_fail++; $display("FAIL limit_stop got %b exp 1", tmr_stop); end
        n_tests++; if (m_cnt !== 10'd3) begin n_fail++; $display("FAIL limit_model got %0d exp 3", m_cnt); end
        tick(6);
        n_tests++; if (elapsed !== 10'd3 || timeout !== 1'b1 || m_cnt !== 10'd3) begin n_fail++; $display("FAIL done_hold got e=%0d to=%b m=%0d exp e=3 to=1 m=3", elapsed, timeout, m_cnt); end
        press(1'b0, 1'b0, 1'b1);
        n_tests++; if (state !== 2'd0 || timeout !== 1'b0 || tmr_reset !== 1'b1) begin n_fail++; $display("FAIL done_clear got st=%0d to=%b rst=%b exp st=0 to=0 rst=1", state, timeout, tmr_reset); end
        tick(1);
        n_tests++; if (elapsed !== 10'd0) begin n_fail++; $display("FAIL clear_elapsed got %0d exp 0", elapsed); end
    endtask

    task automatic test_pause_resume;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        tick(4);
        press(1'b0, 1'b1, 1'b0);
        n_tests++; if (state !== 2'd2 || elapsed !== 10'd1) begin n_fail++; $display("FAIL pause_enter got st=%0d e=%0d exp st=2 e=1", state, elapsed); end
        tick(20);
        n_tests++; if (state !== 2'd2 || elapsed !== 10'd1 || m_cnt !== 10'd1) begin n_fail++; $display("FAIL pause_hold got st=%0d e=%0d m=%0d exp st=2 e=1 m=1", state, elapsed, m_cnt); end
        n_tests++; if (tmr_stop !== 1'b1 || tmr_reset !== 1'b0) begin n_fail++; $display("FAIL pause_ctl got stop=%b rst=%b exp stop=1 rst=0", tmr_stop, tmr_reset); end
        press(1'b0, 1'b1, 1'b0);
        n_tests++; if (state !== 2'd1 || tmr_reset !== 1'b0 || elapsed !== 10'd1) begin n_fail++; $display("FAIL resume got st=%0d rst=%b e=%0d exp st=1 rst=0 e=1", state, tmr_reset, elapsed); end
        tick(1);
        n_tests++; if (elapsed !== 10'd1) begin n_fail++; $display("FAIL resume_e1 got %0d exp 1", elapsed); end
        tick(1);
        n_tests++; if (elapsed !== 10'd2 || m_cnt !== 10'd2) begin n_fail++; $display("FAIL resume_e2 got e=%0d m=%0d exp 2", elapsed, m_cnt); end
    endtask

    task automatic test_game_over;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        tick(9);
        game_over = 1'b1;
        tick(1);
        n_tests++; if (state !== 2'd3 || timeout !== 1'b0 || elapsed !== 10'd2) begin n_fail++; $display("FAIL go_done got st=%0d to=%b e=%0d exp st=3 to=0 e=2", state, timeout, elapsed); end
        tick(8);
        n_tests++; if (elapsed !== 10'd2 || m_cnt !== 10'd2 || state !== 2'd3) begin n_fail++; $display("FAIL go_frozen got e=%0d m=%0d st=%0d exp e=2 m=2 st=3", elapsed, m_cnt, state); end
        game_over = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        n_tests++; if (state !== 2'd1 || tmr_reset !== 1'b1) begin n_fail++; $display("FAIL go_restart got st=%0d rst=%b exp st=1 rst=1", state, tmr_reset); end
        tick(1);
        n_tests++; if (elapsed !== 10'd0 || tmr_reset !== 1'b0 || m_cnt !== 10'd0) begin n_fail++; $display("FAIL go_restart_clr got e=%0d rst=%b m=%0d exp e=0 rst=0 m=0", elapsed, tmr_reset, m_cnt); end
    endtask

    task automatic test_game_over_at_limit;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        tick(12);
        game_over = 1'b1;
        tick(1);
        n_tests++; if (state !== 2'd3 || timeout !== 1'b0 || elapsed !== 10'd3) begin n_fail++; $display("FAIL go_limit got st=%0d to=%b e=%0d exp st=3 to=0 e=3", state, timeout, elapsed); end
        game_over = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        btn_start_n = 1'b0;
        tick(50);
        btn_start_n = 1'b1;
        tick(5);
        n_tests++; if (state !== 2'd3 || elapsed !== 10'd3 || timeout !== 1'b1) begin n_fail++; $display("FAIL hold_one_event got st=%0d e=%0d to=%b exp st=3 e=3 to=1", state, elapsed, timeout); end
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        tick(5);
        press(1'b0, 1'b1, 1'b1);
        n_tests++; if (state !== 2'd0 || tmr_reset !== 1'b1) begin n_fail++; $display("FAIL clear_priority got st=%0d rst=%b exp st=0 rst=1", state, tmr_reset); end
    endtask

    task automatic test_async_reset;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        tick(9);
        n_tests++; if (elapsed !== 10'd2) begin n_fail++; $display("FAIL arst_pre got %0d exp 2", elapsed); end
        #2;
        reset = 1'b1;
        #1;
        n_tests++; if (state !== 2'd0 || tmr_reset !== 1'b1 || tmr_stop !== 1'b1 || elapsed !== 10'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL arst_outputs got st=%0d rst=%b stop=%b e=%0d to=%b exp 0 1 1 0 0", state, tmr_reset, tmr_stop, elapsed, timeout); end
        #2;
        reset = 1'b0;
        tick(1);
        n_tests++; if (state !== 2'd0 || m_cnt !== 10'd0) begin n_fail++; $display("FAIL arst_after got st=%0d m=%0d exp st=0 m=0", state, m_cnt); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_start_timeout();
        test_pause_resume();
        test_game_over();
        test_game_over_at_limit();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
